// File: rtl/ctrl_pipeline.sv
// Control pipeline after decode: carries the packed control bundle through DEPTH
// stages with stall/flush/freeze handling and saturating retire/bubble statistics.
module ctrl_pipeline #(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic                      id_valid,
  input  logic                      nop_sel,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      freeze,
  output logic                      id_ready,
  output logic [DEPTH*CTRL_W-1:0]   stage_ctrl,
  output logic [DEPTH-1:0]          stage_valid,
  output logic [CTRL_W-1:0]         wb_ctrl,
  output logic                      wb_valid,
  output logic [CNT_W-1:0]          retired_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [CNT_W-1:0]             retired_q, retired_d;
  logic [CNT_W-1:0]             bubble_q, bubble_d;
  logic                         bubble_in_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Flush outranks stall/nop_sel, but all of them put a bubble into stage 1.
  assign bubble_in_s = flush | stall | nop_sel | ~id_valid;

  // Next-state: shift stages, insert bubbles, update statistics.
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    retired_d = retired_q;
    bubble_d  = bubble_q;
    if (!freeze) begin
      for (int k = 2; k < DEPTH; k++) begin
        ctrl_d[k]  = ctrl_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      ctrl_d[1]  = flush ? {CTRL_W{1'b0}} : ctrl_q[0];
      valid_d[1] = valid_q[0] & ~flush;
      ctrl_d[0]  = bubble_in_s ? {CTRL_W{1'b0}} : id_ctrl;
      valid_d[0] = ~bubble_in_s;
      if (valid_q[DEPTH-1]) begin
        retired_d = sat_inc(retired_q);
      end else begin
        retired_d = retired_q;
      end
      if (bubble_in_s) begin
        bubble_d = sat_inc(bubble_q);
      end else begin
        bubble_d = bubble_q;
      end
    end else begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      retired_d = retired_q;
      bubble_d  = bubble_q;
    end
  end

  // Stage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      valid_q   <= {DEPTH{1'b0}};
      retired_q <= {CNT_W{1'b0}};
      bubble_q  <= {CNT_W{1'b0}};
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
    end
  end

  assign id_ready    = ~stall & ~freeze & ~reset;
  assign stage_ctrl  = ctrl_q;
  assign stage_valid = valid_q;
  assign wb_ctrl     = ctrl_q[DEPTH-1];
  assign wb_valid    = valid_q[DEPTH-1];
  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench: directed scenarios plus random control traffic compared
// against a stage-array reference model, on a default and a 2-bit-counter instance.
module tb_ctrl_pipeline;

  localparam int CW = 16;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] id_ctrl = 16'h0000;
  logic          id_valid = 1'b0;
  logic          nop_sel = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          freeze = 1'b0;

  logic          id_ready, id_ready2;
  logic [D*CW-1:0] stage_ctrl, stage_ctrl2;
  logic [D-1:0]  stage_valid, stage_valid2;
  logic [CW-1:0] wb_ctrl, wb_ctrl2;
  logic          wb_valid, wb_valid2;
  logic [15:0]   retired_cnt, bubble_cnt;
  logic [1:0]    retired_cnt2, bubble_cnt2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: stage k at index k, unbounded counters clipped on compare.
  logic [CW-1:0] m_ctrl [1:D];
  logic          m_val  [1:D];
  int            m_ret = 0;
  int            m_bub = 0;

  ctrl_pipeline #(.CTRL_W(CW), .DEPTH(D), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .nop_sel(nop_sel), .stall(stall), .flush(flush), .freeze(freeze),
    .id_ready(id_ready), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
    .wb_ctrl(wb_ctrl), .wb_valid(wb_valid),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt));

  ctrl_pipeline #(.CTRL_W(CW), .DEPTH(D), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .nop_sel(nop_sel), .stall(stall), .flush(flush), .freeze(freeze),
    .id_ready(id_ready2), .stage_ctrl(stage_ctrl2), .stage_valid(stage_valid2),
    .wb_ctrl(wb_ctrl2), .wb_valid(wb_valid2),
    .retired_cnt(retired_cnt2), .bubble_cnt(bubble_cnt2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int k = 1; k <= D; k++) begin
        m_ctrl[k] = 16'h0000;
        m_val[k]  = 1'b0;
      end
      m_ret = 0;
      m_bub = 0;
    end else if (!freeze) begin
      if (m_val[D]) m_ret++;
      for (int k = D; k >= 2; k--) begin
        m_ctrl[k] = m_ctrl[k-1];
        m_val[k]  = m_val[k-1];
      end
      if (flush) begin
        m_ctrl[2] = 16'h0000;
        m_val[2]  = 1'b0;
      end
      if (flush || stall || nop_sel || !id_valid) begin
        m_ctrl[1] = 16'h0000;
        m_val[1]  = 1'b0;
        m_bub++;
      end else begin
        m_ctrl[1] = id_ctrl;
        m_val[1]  = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [D*CW-1:0] e_sc;
    logic [D-1:0]    e_sv;
    for (int k = 1; k <= D; k++) begin
      e_sc[k*CW-1 -: CW] = m_ctrl[k];
      e_sv[k-1]          = m_val[k];
    end
    check("stage_ctrl", stage_ctrl, e_sc);
    check("stage_valid", stage_valid, e_sv);
    check("wb_ctrl", wb_ctrl, m_ctrl[D]);
    check("wb_valid", wb_valid, m_val[D]);
    check("retired_cnt", retired_cnt, (m_ret > 65535) ? 65535 : m_ret);
    check("bubble_cnt", bubble_cnt, (m_bub > 65535) ? 65535 : m_bub);
    check("sat_stage_ctrl", stage_ctrl2, e_sc);
    check("sat_wb_valid", wb_valid2, m_val[D]);
    check("sat_retired_cnt", retired_cnt2, (m_ret > 3) ? 3 : m_ret);
    check("sat_bubble_cnt", bubble_cnt2, (m_bub > 3) ? 3 : m_bub);
  endtask

  // Apply one cycle of inputs at the falling edge; compare after the next rising edge.
  task automatic cycle(input logic r, input logic fz, input logic fl, input logic st,
                       input logic nop, input logic v, input logic [CW-1:0] c);
    reset = r; freeze = fz; flush = fl; stall = st; nop_sel = nop; id_valid = v; id_ctrl = c;
    #1;
    check("id_ready", id_ready, !st && !fz && !r);
    check("sat_id_ready", id_ready2, !st && !fz && !r);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 16'h0000);
    check("rst_valid", stage_valid, 3'b000);

    // Fill latency
    cycle(0, 0, 0, 0, 0, 1, 16'h0011);
    cycle(0, 0, 0, 0, 0, 1, 16'h0022);
    cycle(0, 0, 0, 0, 0, 1, 16'h0033);
    check("lat_wb_ctrl", wb_ctrl, 16'h0011);
    check("lat_wb_valid", wb_valid, 1'b1);
    cycle(0, 0, 0, 0, 0, 1, 16'h0044);
    check("lat_wb_next", wb_ctrl, 16'h0022);
    check("lat_retired", retired_cnt, 16'd1);

    // Stall with pipe {44,33,22}
    cycle(0, 0, 0, 1, 0, 1, 16'h0055);
    check("stall_valid", stage_valid, 3'b110);
    check("stall_bubble", bubble_cnt, 16'd1);
    check("stall_wb", wb_ctrl, 16'h0033);

    // Flush with pipe {88,77,66}
    cycle(0, 0, 0, 0, 0, 1, 16'h0066);
    cycle(0, 0, 0, 0, 0, 1, 16'h0077);
    cycle(0, 0, 0, 0, 0, 1, 16'h0088);
    cycle(0, 0, 1, 1, 1, 1, 16'h0099);
    check("flush_valid", stage_valid, 3'b100);
    check("flush_ctrl", stage_ctrl, 48'h0077_0000_0000);
    check("flush_bubble", bubble_cnt, 16'd2);

    // Freeze with full pipe
    cycle(0, 0, 0, 0, 0, 1, 16'h00A1);
    cycle(0, 0, 0, 0, 0, 1, 16'h00A2);
    cycle(0, 0, 0, 0, 0, 1, 16'h00A3);
    cycle(0, 1, 1, 1, 0, 1, 16'h00BB);
    cycle(0, 1, 0, 0, 1, 0, 16'h00CC);
    check("frz_ctrl", stage_ctrl, 48'h00A1_00A2_00A3);
    check("frz_valid", stage_valid, 3'b111);
    check("frz_bubble", bubble_cnt, 16'd2);
    cycle(0, 0, 0, 0, 0, 1, 16'h00A4);
    check("frz_resume", wb_ctrl, 16'h00A2);

    // nop_sel for three edges after reset
    cycle(1, 1, 1, 1, 0, 1, 16'h1234);
    cycle(0, 0, 0, 0, 1, 1, 16'h0101);
    cycle(0, 0, 0, 0, 1, 1, 16'h0202);
    cycle(0, 0, 0, 0, 1, 1, 16'h0303);
    check("nop_valid", stage_valid, 3'b000);
    check("nop_ctrl", stage_ctrl, 48'h0);
    check("nop_bubble", bubble_cnt, 16'd3);

    // Counter saturation, then reset mid-stream
    cycle(1, 0, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 1, 16'h0400 + 16'(i));
    check("sat_ret3", retired_cnt2, 2'd3);
    check("wide_ret5", retired_cnt, 16'd5);
    cycle(1, 0, 0, 0, 0, 1, 16'h0500);
    check("midrst_valid", stage_valid2, 3'b000);
    check("midrst_ret", retired_cnt2, 2'd0);
    check("midrst_wb", wb_ctrl, 16'h0000);
    cycle(0, 0, 0, 0, 0, 1, 16'h0600);
    check("post_rst_cap", stage_ctrl[15:0], 16'h0600);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 80),
            16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
